// File: rtl/systolic_writeback.sv
// ---------------------------------------------------------------------------
// systolic_writeback
//
// Purpose:
//   Drain stage of the systolic array. Each array row delivers its results as
//   an independent stream (D[r] qualified by valid_D[r]); this block turns
//   every accepted beat into a write to bank r of the banked result memory.
//   Each lane counts its own beats and tiles, so the one-cycle row-to-row
//   skew of the array drain needs no alignment logic. A small FSM tracks the
//   writeback of a whole MxM result matrix and pulses done at its end.
//
// Ports:
//   clk      in   clock
//   rst      in   synchronous active-high reset
//   D        in   [D_W_ACC-1:0] x N1 result data, one entry per array row
//   valid_D  in   [N1-1:0] per-row result valid
//   wr_en    out  [N1-1:0] per-bank write enable (registered)
//   wr_addr  out  [$clog2(M*M/N1)-1:0] x N1 per-bank write address
//   wr_data  out  [D_W_ACC-1:0] x N1 per-bank write data
//   busy     out  matrix writeback in progress
//   done     out  one-cycle pulse once the full matrix has been written
//
// Configuration:
//   WB_RELU_EN  when defined, negative results are written as zero (ReLU).
//               Addressing and timing are the same either way.
// ---------------------------------------------------------------------------
module systolic_writeback #(
  parameter int D_W_ACC = 16,
  parameter int N1      = 4,
  parameter int N2      = 4,
  parameter int M       = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [D_W_ACC-1:0]               D       [N1],
  input  logic [N1-1:0]                    valid_D,
  output logic [N1-1:0]                    wr_en,
  output logic [$clog2((M*M)/N1)-1:0]      wr_addr [N1],
  output logic [D_W_ACC-1:0]               wr_data [N1],
  output logic                             busy,
  output logic                             done
);

  // Bank depth and the tile grid as seen by one lane.
  localparam int AW = $clog2((M*M)/N1);
  localparam int TC = M / N2;   // tiles per tile row
  localparam int TR = M / N1;   // tile rows
  localparam int KW = (N2 > 1) ? $clog2(N2) : 1;
  localparam int CW = (TC > 1) ? $clog2(TC) : 1;
  localparam int RW = (TR > 1) ? $clog2(TR) : 1;

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    DONE
  } state_t;

  // Per-lane counters. tileRow/tileCol together form the lane's tile index
  // (t = tileRow*TC + tileCol); keeping them split avoids a divider.
  logic [KW-1:0]      beat_q    [N1];
  logic [KW-1:0]      beat_d    [N1];
  logic [CW-1:0]      tileCol_q [N1];
  logic [CW-1:0]      tileCol_d [N1];
  logic [RW-1:0]      tileRow_q [N1];
  logic [RW-1:0]      tileRow_d [N1];
  logic [N1-1:0]      finNow;

  logic [AW-1:0]      laneAddr  [N1];
  logic [D_W_ACC-1:0] laneData  [N1];

  logic [N1-1:0]      wrEn_q;
  logic [AW-1:0]      wrAddr_q  [N1];
  logic [D_W_ACC-1:0] wrData_q  [N1];

  logic [N1-1:0]      laneFin_q;
  logic [N1-1:0]      laneFin_d;
  state_t             state_q;
  logic               busy_q;
  logic               done_q;

  // Counter next-state and address generation for every lane. The last PE
  // column drains first, so beat k lands in tile column N2-1-k. A lane that
  // wraps its final tile flags finNow for the matrix-completion tracking.
  always_comb begin
    for (int r = 0; r < N1; r++) begin
      beat_d[r]    = beat_q[r];
      tileCol_d[r] = tileCol_q[r];
      tileRow_d[r] = tileRow_q[r];
      finNow[r]    = 1'b0;

      laneAddr[r] = AW'(tileRow_q[r]) * AW'(M)
                  + AW'(tileCol_q[r]) * AW'(N2)
                  + (AW'(N2 - 1) - AW'(beat_q[r]));

      if (valid_D[r]) begin
        if (beat_q[r] == KW'(N2 - 1)) begin
          beat_d[r] = '0;
          if (tileCol_q[r] == CW'(TC - 1)) begin
            tileCol_d[r] = '0;
            if (tileRow_q[r] == RW'(TR - 1)) begin
              tileRow_d[r] = '0;
              finNow[r]    = 1'b1;
            end else begin
              tileRow_d[r] = tileRow_q[r] + 1'b1;
            end
          end else begin
            tileCol_d[r] = tileCol_q[r] + 1'b1;
          end
        end else begin
          beat_d[r] = beat_q[r] + 1'b1;
        end
      end
    end
  end

  // Write data path: optionally clamp negative accumulator values to zero.
  always_comb begin
    for (int r = 0; r < N1; r++) begin
`ifdef WB_RELU_EN
      laneData[r] = D[r][D_W_ACC-1] ? '0 : D[r];
`else
      laneData[r] = D[r];
`endif
    end
  end

  // Lane registers. Address and data only load on an accepted beat so that
  // they hold their last values while wr_en is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      wrEn_q <= '0;
      for (int r = 0; r < N1; r++) begin
        beat_q[r]    <= '0;
        tileCol_q[r] <= '0;
        tileRow_q[r] <= '0;
        wrAddr_q[r]  <= '0;
        wrData_q[r]  <= '0;
      end
    end else begin
      wrEn_q <= valid_D;
      for (int r = 0; r < N1; r++) begin
        beat_q[r]    <= beat_d[r];
        tileCol_q[r] <= tileCol_d[r];
        tileRow_q[r] <= tileRow_d[r];
        if (valid_D[r]) begin
          wrAddr_q[r] <= laneAddr[r];
          wrData_q[r] <= laneData[r];
        end
      end
    end
  end

  // Finished-lane flags are sticky until the DONE cycle wipes them. A lane
  // completing during DONE itself still gets recorded for the next matrix.
  always_comb begin
    laneFin_d = ((state_q == DONE) ? '0 : laneFin_q) | finNow;
  end

  // Matrix-level FSM with registered busy/done. The completion test uses the
  // registered finish flags, which places done one cycle after the final
  // lane's last write enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      laneFin_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      laneFin_q <= laneFin_d;
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (|valid_D) begin
            state_q <= ACTIVE;
            busy_q  <= 1'b1;
          end else begin
            busy_q  <= 1'b0;
          end
        end
        ACTIVE: begin
          if (&laneFin_q) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign wr_en   = wrEn_q;
  assign wr_addr = wrAddr_q;
  assign wr_data = wrData_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_systolic_writeback.sv
// ---------------------------------------------------------------------------
// tb_systolic_writeback
//
// Directed bench for systolic_writeback with M=8, N1=N2=4. Expected values
// are hand-computed constants: each lane writes tiles in the address order
// 3,2,1,0 / 7,6,5,4 / 11,10,9,8 / 15,14,13,12.
// ---------------------------------------------------------------------------
module tb_systolic_writeback;

  localparam int DW = 16;
  localparam int N1 = 4;
  localparam int N2 = 4;
  localparam int M  = 8;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] D       [N1];
  logic [N1-1:0] valid_D;
  logic [N1-1:0] wr_en;
  logic [AW-1:0] wr_addr [N1];
  logic [DW-1:0] wr_data [N1];
  logic          busy;
  logic          done;

  int vectorCount = 0;
  int missCount   = 0;

  // Address sequence for one lane across the four tiles of a matrix.
  logic [3:0] addrTable [16] = '{4'd3, 4'd2, 4'd1, 4'd0, 4'd7, 4'd6, 4'd5, 4'd4,
                                 4'd11, 4'd10, 4'd9, 4'd8, 4'd15, 4'd14, 4'd13, 4'd12};

  logic [15:0]   seen  [N1];
  int            beats [N1];
  logic [N1-1:0] vec;
  logic [DW-1:0] reluExp;

  systolic_writeback #(
    .D_W_ACC (DW),
    .N1      (N1),
    .N2      (N2),
    .M       (M)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .D       (D),
    .valid_D (valid_D),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  // Drive valid for one cycle, then settle just after the capturing edge so
  // the registered outputs for that beat can be sampled.
  task automatic applyStimulus(input logic [N1-1:0] v);
    valid_D = v;
    @(posedge clk);
    #1;
  endtask

  // Single comparison point: counts every check and reports any mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectorCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic doReset();
    rst = 1'b1;
    applyStimulus('0);
    applyStimulus('0);
    rst = 1'b0;
  endtask

  initial begin
    rst     = 1'b1;
    valid_D = '0;
    for (int r = 0; r < N1; r++) D[r] = 16'd7;

    // Reset held with all valids high: nothing may be written.
    $display("[TB] reset behaviour");
    for (int i = 0; i < 2; i++) begin
      applyStimulus(4'hF);
      checkOutput("rst_wr_en", wr_en, 4'h0);
      checkOutput("rst_busy", busy, 1'b0);
      checkOutput("rst_done", done, 1'b0);
    end
    checkOutput("rst_addr0", wr_addr[0], 4'd0);
    checkOutput("rst_data0", wr_data[0], 16'd0);
    rst = 1'b0;
    applyStimulus(4'h0);
    checkOutput("post_rst_wr_en", wr_en, 4'h0);
    checkOutput("post_rst_busy", busy, 1'b0);
    checkOutput("post_rst_done", done, 1'b0);

    // Single tile on lane 0.
    $display("[TB] single tile lane 0");
    for (int i = 0; i < 4; i++) begin
      D[0] = 16'(10 + i);
      applyStimulus(4'b0001);
      checkOutput("tile_wr_en", wr_en, 4'b0001);
      checkOutput("tile_addr", wr_addr[0], 32'(3 - i));
      checkOutput("tile_data", wr_data[0], 32'(10 + i));
      checkOutput("tile_busy", busy, 1'b1);
    end
    applyStimulus(4'b0000);
    checkOutput("idle_wr_en", wr_en, 4'b0000);
    checkOutput("hold_addr", wr_addr[0], 4'd0);
    checkOutput("hold_data", wr_data[0], 16'd13);
    checkOutput("tile_no_done", done, 1'b0);

    // Lane 1 with a gap after every beat.
    $display("[TB] gapped lane 1");
    doReset();
    for (int i = 0; i < 8; i++) begin
      D[1] = 16'(20 + i);
      if ((i % 2) == 0) begin
        applyStimulus(4'b0010);
        checkOutput("gap_wr_en", wr_en, 4'b0010);
        checkOutput("gap_addr", wr_addr[1], 32'(3 - i / 2));
        checkOutput("gap_data", wr_data[1], 32'(20 + i));
      end else begin
        applyStimulus(4'b0000);
        checkOutput("gap_idle", wr_en, 4'b0000);
      end
    end

    // Full matrix with the skewed drain: lane r runs 16 beats from cycle r.
    $display("[TB] skewed full matrix");
    doReset();
    for (int r = 0; r < N1; r++) begin
      seen[r]  = '0;
      beats[r] = 0;
    end
    for (int c = 0; c < 19; c++) begin
      for (int r = 0; r < N1; r++) begin
        vec[r] = (c >= r) && (c < r + 16);
        D[r]   = 16'(r * 100 + c - r);
      end
      applyStimulus(vec);
      checkOutput("skew_wr_en", wr_en, vec);
      checkOutput("skew_busy", busy, 1'b1);
      checkOutput("skew_done", done, 1'b0);
      for (int r = 0; r < N1; r++) begin
        if (vec[r]) begin
          checkOutput($sformatf("skew_addr%0d", r), wr_addr[r], addrTable[beats[r]]);
          checkOutput($sformatf("skew_data%0d", r), wr_data[r], 32'(r * 100 + beats[r]));
          seen[r][wr_addr[r]] = 1'b1;
          beats[r]++;
        end
      end
    end
    for (int r = 0; r < N1; r++) begin
      checkOutput($sformatf("cover%0d", r), seen[r], 16'hFFFF);
    end
    applyStimulus(4'b0000);
    checkOutput("done_pulse", done, 1'b1);
    checkOutput("done_busy", busy, 1'b0);
    applyStimulus(4'b0000);
    checkOutput("done_clear", done, 1'b0);
    checkOutput("idle_busy", busy, 1'b0);

    // Reset part-way through a matrix on lane 0.
    $display("[TB] reset mid matrix");
    doReset();
    for (int i = 0; i < 7; i++) begin
      D[0] = 16'(40 + i);
      applyStimulus(4'b0001);
    end
    checkOutput("pre_rst_addr", wr_addr[0], 4'd5);
    rst  = 1'b1;
    D[0] = 16'd99;
    applyStimulus(4'b0001);
    checkOutput("mid_rst_wr_en", wr_en, 4'b0000);
    checkOutput("mid_rst_busy", busy, 1'b0);
    rst  = 1'b0;
    D[0] = 16'd55;
    applyStimulus(4'b0001);
    checkOutput("restart_wr_en", wr_en, 4'b0001);
    checkOutput("restart_addr", wr_addr[0], 4'd3);
    checkOutput("restart_data", wr_data[0], 16'd55);

    // Negative and positive data on the next two beats.
`ifdef WB_RELU_EN
    reluExp = 16'h0000;
`else
    reluExp = 16'hFFF0;
`endif
    D[0] = 16'hFFF0;
    applyStimulus(4'b0001);
    checkOutput("neg_addr", wr_addr[0], 4'd2);
    checkOutput("neg_data", wr_data[0], reluExp);
    D[0] = 16'h0005;
    applyStimulus(4'b0001);
    checkOutput("pos_addr", wr_addr[0], 4'd1);
    checkOutput("pos_data", wr_data[0], 16'h0005);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(4'b0000);
      checkOutput("rst_no_done", done, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
